// File: rtl/or_reduce_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined OR-reduce tree.
//   clog         : number of tree levels for n inputs at a given radix (minimum 1)
//   nodes        : node count of tree level k
//   level_inputs : number of words entering tree level k
package or_reduce_pipe_pkg;

  localparam int unsigned MODE_PASS   = 0;
  localparam int unsigned MODE_STICKY = 1;

  // radix^e
  function automatic int unsigned pow_r(int unsigned radix, int unsigned e);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < e; i++) p = p * radix;
    return p;
  endfunction

  // ceil(log_radix(n)), never below 1
  function automatic int unsigned clog(int unsigned n, int unsigned radix);
    int unsigned lv;
    lv = 1;
    for (int i = 0; i < 32; i++) begin
      if (pow_r(radix, lv) < n) lv = lv + 1;
    end
    return lv;
  endfunction

  // ceil(n / radix^(k+1))
  function automatic int unsigned nodes(int unsigned n, int unsigned radix, int unsigned k);
    int unsigned dv;
    dv = pow_r(radix, k + 1);
    return (n + dv - 1) / dv;
  endfunction

  function automatic int unsigned level_inputs(int unsigned n, int unsigned radix, int unsigned k);
    if (k == 0) return n;
    return nodes(n, radix, k - 1);
  endfunction

endpackage

// File: rtl/or_reduce_node.sv
// One registered tree node: bitwise OR of RADIX words of WIDTH bits.
//   clk_i, rst_i : clock, synchronous active-high reset
//   ce_i         : clock enable, 0 holds the register
//   d_i          : RADIX packed words, word r = d_i[r*WIDTH +: WIDTH]
//   z_o          : registered OR of all words
module or_reduce_node #(
  parameter int unsigned RADIX = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ce_i,
  input  logic [RADIX*WIDTH-1:0] d_i,
  output logic [WIDTH-1:0]       z_o
);

  logic [WIDTH-1:0] z_d;
  logic [WIDTH-1:0] z_q;

  // OR across the group
  always_comb begin
    z_d = '0;
    for (int r = 0; r < int'(RADIX); r++) z_d = z_d | d_i[r*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     z_q <= '0;
    else if (ce_i) z_q <= z_d;
  end

  assign z_o = z_q;

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined, masked OR reduction of NUM_IN words through a registered radix-RADIX
// tree, with optional sticky accumulation of results.
//   CK, CD : clock, synchronous active-high reset
//   CE     : clock enable for pipeline, valid and accumulator registers
//   VI     : input sample valid
//   D      : NUM_IN words, word i = D[i*WIDTH +: WIDTH]
//   MASK   : 1 excludes word i
//   CLR    : sticky accumulator clear (acts even with CE=0)
//   VO     : output valid
//   Z      : OR result (or accumulated OR when STICKY=1)
//   ZANY   : reduction OR of Z, registered with Z
module or_reduce_pipe
  import or_reduce_pipe_pkg::*;
#(
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned RADIX  = 4,
  parameter int unsigned STICKY = MODE_PASS
) (
  input  logic                    CK,
  input  logic                    CD,
  input  logic                    CE,
  input  logic                    VI,
  input  logic [NUM_IN*WIDTH-1:0] D,
  input  logic [NUM_IN-1:0]       MASK,
  input  logic                    CLR,
  output logic                    VO,
  output logic [WIDTH-1:0]        Z,
  output logic                    ZANY
);

  localparam int unsigned LEVELS = clog(NUM_IN, RADIX);

  // lvl[0] holds the masked inputs, lvl[k+1] the registered outputs of tree level k
  logic [WIDTH-1:0] lvl [0:LEVELS][0:NUM_IN-1];
  logic [LEVELS-1:0] v_q;
  logic             vo_q;
  logic [WIDTH-1:0] z_d;
  logic [WIDTH-1:0] z_q;
  logic             zany_q;
  logic [WIDTH-1:0] tree_out;

  for (genvar i = 0; i < int'(NUM_IN); i++) begin : g_mask
    assign lvl[0][i] = D[i*WIDTH +: WIDTH] & ~{WIDTH{MASK[i]}};
  end

  for (genvar k = 0; k < int'(LEVELS); k++) begin : g_lvl
    localparam int unsigned NIN = level_inputs(NUM_IN, RADIX, k);
    localparam int unsigned NN  = nodes(NUM_IN, RADIX, k);
    for (genvar n = 0; n < int'(NUM_IN); n++) begin : g_node
      if (n < int'(NN)) begin : g_used
        logic [RADIX*WIDTH-1:0] din;
        // partial last group: missing inputs read as 0
        for (genvar r = 0; r < int'(RADIX); r++) begin : g_in
          if (n*int'(RADIX) + r < int'(NIN)) begin : g_wire
            assign din[r*WIDTH +: WIDTH] = lvl[k][n*int'(RADIX) + r];
          end else begin : g_tie
            assign din[r*WIDTH +: WIDTH] = '0;
          end
        end
        or_reduce_node #(
          .RADIX (RADIX),
          .WIDTH (WIDTH)
        ) u_node (
          .clk_i (CK),
          .rst_i (CD),
          .ce_i  (CE),
          .d_i   (din),
          .z_o   (lvl[k+1][n])
        );
      end else begin : g_unused
        assign lvl[k+1][n] = '0;
      end
    end
  end

  assign tree_out = lvl[LEVELS][0];

  // Output stage next value; pass mode only updates Z on a valid result so it holds afterwards
  always_comb begin
    z_d = z_q;
    if (STICKY == MODE_STICKY) begin
      if (CE)       z_d = (CLR ? '0 : z_q) | (v_q[LEVELS-1] ? tree_out : '0);
      else if (CLR) z_d = '0;
    end else begin
      if (CE && v_q[LEVELS-1]) z_d = tree_out;
    end
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      v_q    <= '0;
      vo_q   <= 1'b0;
      z_q    <= '0;
      zany_q <= 1'b0;
    end else begin
      z_q    <= z_d;
      zany_q <= |z_d;
      if (CE) begin
        vo_q   <= v_q[LEVELS-1];
        v_q[0] <= VI;
        for (int k = 1; k < int'(LEVELS); k++) v_q[k] <= v_q[k-1];
      end
    end
  end

  assign VO   = vo_q;
  assign Z    = z_q;
  assign ZANY = zany_q;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed bench: pass-mode (8 in, radix 4), sticky-mode (8 in, radix 4) and
// pass-mode (5 in, radix 2) instances share one stimulus set.
module tb_or_reduce_pipe;

  logic        ck = 1'b0;
  logic        cd, ce, vi, clr;
  logic [31:0] d;
  logic [7:0]  mask;

  logic [2:0]  vo;
  logic [3:0]  z [3];
  logic [2:0]  zany;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  or_reduce_pipe #(.NUM_IN(8), .WIDTH(4), .RADIX(4), .STICKY(0)) u_pass (
    .CK(ck), .CD(cd), .CE(ce), .VI(vi), .D(d), .MASK(mask), .CLR(clr),
    .VO(vo[0]), .Z(z[0]), .ZANY(zany[0]));

  or_reduce_pipe #(.NUM_IN(8), .WIDTH(4), .RADIX(4), .STICKY(1)) u_stk (
    .CK(ck), .CD(cd), .CE(ce), .VI(vi), .D(d), .MASK(mask), .CLR(clr),
    .VO(vo[1]), .Z(z[1]), .ZANY(zany[1]));

  or_reduce_pipe #(.NUM_IN(5), .WIDTH(4), .RADIX(2), .STICKY(0)) u_p5 (
    .CK(ck), .CD(cd), .CE(ce), .VI(vi), .D(d[19:0]), .MASK(mask[4:0]), .CLR(clr),
    .VO(vo[2]), .Z(z[2]), .ZANY(zany[2]));

  typedef struct {
    logic [31:0] d;
    logic [7:0]  mask;
    logic [3:0]  exp8;
    logic [3:0]  exp5;
  } vec_t;

  typedef struct {
    logic        cd, ce, vi, clr;
    logic [31:0] d;
    int          tgt;
    logic        chk_z;
    logic        exp_vo;
    logic [3:0]  exp_z;
  } step_t;

  vec_t  vecs [6];
  step_t steps[$];

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic cd_v, input logic ce_v, input logic vi_v, input logic clr_v,
                     input logic [31:0] d_v, input int tgt_v, input logic chk_v,
                     input logic vo_v, input logic [3:0] z_v);
    step_t s;
    s.cd = cd_v; s.ce = ce_v; s.vi = vi_v; s.clr = clr_v; s.d = d_v;
    s.tgt = tgt_v; s.chk_z = chk_v; s.exp_vo = vo_v; s.exp_z = z_v;
    steps.push_back(s);
  endtask

  initial begin
    // single samples: d, mask, expected Z for 8-input and 5-input instances
    vecs[0] = '{32'h0800_2000, 8'h00, 4'hA, 4'h2};
    vecs[1] = '{32'h0800_2000, 8'h48, 4'h0, 4'h0};
    vecs[2] = '{32'hFFFF_FFFF, 8'hFF, 4'h0, 4'h0};
    vecs[3] = '{32'h1000_0001, 8'h00, 4'h1, 4'h1};
    vecs[4] = '{32'h8421_0000, 8'h0F, 4'hF, 4'h1};
    vecs[5] = '{32'h8421_0000, 8'hF0, 4'h0, 4'h0};

    // pass streaming, no stall: VO edges 3..6
    add(0,1,1,0,32'h1,0,0,0,4'h0);
    add(0,1,1,0,32'h2,0,0,0,4'h0);
    add(0,1,1,0,32'h4,0,1,1,4'h1);
    add(0,1,1,0,32'h8,0,1,1,4'h2);
    add(0,1,0,0,32'h0,0,1,1,4'h4);
    add(0,1,0,0,32'h0,0,1,1,4'h8);
    add(0,1,0,0,32'h0,0,1,0,4'h8);
    // pass streaming with 2-cycle CE stall: VO delayed by 2
    add(0,1,1,0,32'h1,0,0,0,4'h0);
    add(0,1,1,0,32'h2,0,0,0,4'h0);
    add(0,0,1,0,32'h4,0,0,0,4'h0);
    add(0,0,1,0,32'h4,0,1,0,4'h8);
    add(0,1,1,0,32'h4,0,1,1,4'h1);
    add(0,1,1,0,32'h8,0,1,1,4'h2);
    add(0,1,0,0,32'h0,0,1,1,4'h4);
    add(0,1,0,0,32'h0,0,1,1,4'h8);
    add(0,1,0,0,32'h0,0,1,0,4'h8);
    // sticky: accumulate, clear with coincident result, clear while CE=0
    add(1,1,0,0,32'h0,1,1,0,4'h0);
    add(0,1,1,0,32'h1,1,1,0,4'h0);
    add(0,1,1,0,32'h4,1,1,0,4'h0);
    add(0,1,1,0,32'h8,1,1,1,4'h1);
    add(0,1,0,0,32'h0,1,1,1,4'h5);
    add(0,1,0,1,32'h0,1,1,1,4'h8);
    add(0,0,0,1,32'h0,1,1,1,4'h0);
    add(0,1,0,0,32'h0,1,1,0,4'h0);
    // reset mid-flight, 8-input then 5-input instance
    for (int t = 0; t < 3; t += 2) begin
      add(0,1,1,0,32'hF,t,0,0,4'h0);
      add(1,1,0,0,32'h0,t,1,0,4'h0);
      for (int i = 0; i < 5; i++) add(0,1,0,0,32'h0,t,1,0,4'h0);
    end

    cd = 1'b1; ce = 1'b1; vi = 1'b0; clr = 1'b0; d = '0; mask = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_vo%0d", i), 32'(vo[i]), 32'h0);
      chk($sformatf("reset_z%0d", i), 32'(z[i]), 32'h0);
      chk($sformatf("reset_zany%0d", i), 32'(zany[i]), 32'h0);
    end
    cd = 1'b0;

    for (int i = 0; i < 6; i++) begin
      d = vecs[i].d; mask = vecs[i].mask; vi = 1'b1;
      tick();
      chk($sformatf("v%0d_e1_vo", i), 32'(vo[0]), 32'h0);
      d = '0; mask = '0; vi = 1'b0;
      tick();
      chk($sformatf("v%0d_e2_vo", i), 32'(vo[0]), 32'h0);
      tick();
      chk($sformatf("v%0d_e3_vo", i), 32'(vo[0]), 32'h1);
      chk($sformatf("v%0d_e3_z", i), 32'(z[0]), 32'(vecs[i].exp8));
      chk($sformatf("v%0d_e3_zany", i), 32'(zany[0]), 32'(|vecs[i].exp8));
      chk($sformatf("v%0d_p5_e3_vo", i), 32'(vo[2]), 32'h0);
      tick();
      chk($sformatf("v%0d_e4_vo", i), 32'(vo[0]), 32'h0);
      chk($sformatf("v%0d_e4_zhold", i), 32'(z[0]), 32'(vecs[i].exp8));
      chk($sformatf("v%0d_p5_e4_vo", i), 32'(vo[2]), 32'h1);
      chk($sformatf("v%0d_p5_e4_z", i), 32'(z[2]), 32'(vecs[i].exp5));
      chk($sformatf("v%0d_p5_e4_zany", i), 32'(zany[2]), 32'(|vecs[i].exp5));
      tick();
      chk($sformatf("v%0d_p5_e5_vo", i), 32'(vo[2]), 32'h0);
    end

    for (int i = 0; i < steps.size(); i++) begin
      cd = steps[i].cd; ce = steps[i].ce; vi = steps[i].vi;
      clr = steps[i].clr; d = steps[i].d; mask = '0;
      tick();
      chk($sformatf("step%0d_vo", i), 32'(vo[steps[i].tgt]), 32'(steps[i].exp_vo));
      if (steps[i].chk_z) begin
        chk($sformatf("step%0d_z", i), 32'(z[steps[i].tgt]), 32'(steps[i].exp_z));
        chk($sformatf("step%0d_zany", i), 32'(zany[steps[i].tgt]), 32'(|steps[i].exp_z));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
